// File: rtl/first_pos.sv
// first_pos: synchronizes asynchronous start/stop events and a reference
// clock into the clk domain, then emits a TDC_start pulse for an accepted
// event followed by a TDC_stop pulse on the next reference-clock rise.
module first_pos #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_i,
  input  logic start,
  input  logic stop,
  output logic TDC_start,
  output logic TDC_stop
);

  typedef enum logic {
    IDLE,
    WAIT_REF
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t state, state_nxt;

  // Synchronizer chains: bit 0 samples the raw input, MSB is the settled value.
  logic [SYNC_STAGES-1:0] sync_start, sync_stop, sync_ref;
  logic                   hist_start, hist_stop, hist_ref;
  logic                   rise_start, rise_stop, rise_ref;

  logic [15:0] cnt, cnt_nxt;
  logic        start_nxt, stop_nxt;

  // Synchronizer chains plus one history flop per input; reset_n is active-high.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync_start <= '0;
      sync_stop  <= '0;
      sync_ref   <= '0;
      hist_start <= 1'b0;
      hist_stop  <= 1'b0;
      hist_ref   <= 1'b0;
    end else begin
      sync_start <= {sync_start[SYNC_STAGES-2:0], start};
      sync_stop  <= {sync_stop[SYNC_STAGES-2:0], stop};
      sync_ref   <= {sync_ref[SYNC_STAGES-2:0], clk_i};
      hist_start <= sync_start[SYNC_STAGES-1];
      hist_stop  <= sync_stop[SYNC_STAGES-1];
      hist_ref   <= sync_ref[SYNC_STAGES-1];
    end
  end

  assign rise_start = sync_start[SYNC_STAGES-1] & ~hist_start;
  assign rise_stop  = sync_stop[SYNC_STAGES-1]  & ~hist_stop;
  assign rise_ref   = sync_ref[SYNC_STAGES-1]   & ~hist_ref;

  // State, wait counter and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      TDC_start <= 1'b0;
      TDC_stop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      TDC_start <= start_nxt;
      TDC_stop  <= stop_nxt;
    end
  end

  // Next-state logic. A reference rise in the event cycle is ignored simply
  // because the FSM is still in IDLE then; event rises in WAIT_REF are dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise_start || rise_stop) begin
          state_nxt = WAIT_REF;
          start_nxt = 1'b1;
        end
      end
      WAIT_REF: begin
        if (rise_ref) begin
          state_nxt = IDLE;
          stop_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_first_pos.sv
// tb_first_pos: scoreboard bench for first_pos. Expected pulses are queued
// when stimulus is driven and matched by a monitor sampling on negedge clk.
`timescale 1ns/1ns
module tb_first_pos;

  localparam int unsigned TMO = 16;

  logic clk      = 1'b0;
  logic reset_n  = 1'b1;
  logic clk_i    = 1'b0;
  logic start    = 1'b0;
  logic stop     = 1'b0;
  logic clk_i_en = 1'b1;
  logic tdc_start, tdc_stop;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    bit     is_stop;
    longint t0;
  } exp_t;

  exp_t sb[$];

  int unsigned n_exp_start = 0, n_exp_stop = 0;
  int unsigned n_start = 0, n_stop = 0;
  longint      last_start_t = 0;

  first_pos #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_i    (clk_i),
    .start    (start),
    .stop     (stop),
    .TDC_start(tdc_start),
    .TDC_stop (tdc_stop)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // 90 ns reference clock, forced low while disabled
  initial forever begin
    #45;
    clk_i = clk_i_en ? ~clk_i : 1'b0;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit with_stop);
    exp_t e;
    e.is_stop = 1'b0;
    e.t0      = $time;
    sb.push_back(e);
    n_exp_start++;
    if (with_stop) begin
      e.is_stop = 1'b1;
      sb.push_back(e);
      n_exp_stop++;
    end
  endtask

  // Drive a 40 ns pulse on start (ch=0) or stop (ch=1); optionally aligned
  // 5 ns after a reference rise so the next one is a known 85 ns away.
  task automatic pulse(input bit ch, input bit align, input bit with_stop);
    if (align) begin
      @(posedge clk_i);
      #5;
    end
    push_exp(with_stop);
    if (ch) stop = 1'b1;
    else    start = 1'b1;
    #40;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Monitor: pulse widths, overlap, ordering and latency against the queue
  int     w_start = 0, w_stop = 0;
  logic   p_start = 1'b0, p_stop = 1'b0;
  always @(negedge clk) begin
    exp_t   e;
    longint d;
    if (tdc_start || tdc_stop) check("overlap", longint'(tdc_start & tdc_stop), 0);

    if (tdc_start && !p_start) begin
      n_start++;
      last_start_t = $time;
      check("sb_has_start", longint'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_start", longint'(e.is_stop), 0);
        d = $time - e.t0;
        if (d < 45 || d > 75) $display("start latency %0d ns", d);
        check("start_lat_ok", longint'(d >= 45 && d <= 75), 1);
      end
    end
    if (tdc_stop && !p_stop) begin
      n_stop++;
      check("sb_has_stop", longint'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_stop", longint'(e.is_stop), 1);
        d = $time - last_start_t;
        if (d < 20 || d > 180) $display("stop latency %0d ns", d);
        check("stop_lat_ok", longint'(d >= 20 && d <= 180), 1);
      end
    end

    if (tdc_start) w_start++;
    else if (w_start != 0) begin
      check("start_width", w_start, 1);
      w_start = 0;
    end
    if (tdc_stop) w_stop++;
    else if (w_stop != 0) begin
      check("stop_width", w_stop, 1);
      w_stop = 0;
    end
    p_start = tdc_start;
    p_stop  = tdc_stop;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gap;
    int unsigned stops_before;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tdc_start", tdc_start, 0);
    check("rst_tdc_stop", tdc_stop, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("post_rst_start", tdc_start, 0);
    check("post_rst_stop", tdc_stop, 0);
    repeat (5) @(negedge clk);

    // Basic start pair, then an independent stop-channel pair
    pulse(1'b0, 1'b1, 1'b1);
    drain("basic_drain");
    repeat (14) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b1);
    drain("stopch_drain");
    repeat (10) @(negedge clk);

    // Busy drop: stop 40 ns after start lands in WAIT_REF and is discarded
    @(posedge clk_i);
    #5;
    push_exp(1'b1);
    start = 1'b1;
    #40;
    start = 1'b0;
    stop  = 1'b1;
    #40;
    stop  = 1'b0;
    drain("busy_drain");
    repeat (20) @(negedge clk);
    check("busy_starts", n_start, n_exp_start);

    // Simultaneous start and stop form one event
    @(posedge clk_i);
    #5;
    push_exp(1'b1);
    start = 1'b1;
    stop  = 1'b1;
    #40;
    start = 1'b0;
    stop  = 1'b0;
    drain("simul_drain");
    repeat (20) @(negedge clk);

    // Timeout: no reference edges, start yields TDC_start only
    clk_i_en = 1'b0;
    #100;
    stops_before = n_stop;
    pulse(1'b0, 1'b0, 1'b0);
    repeat (TMO + 24) @(negedge clk);
    check("timeout_no_stop", n_stop, stops_before);
    drain("timeout_drain");
    clk_i_en = 1'b1;
    #100;
    pulse(1'b0, 1'b1, 1'b1);
    drain("after_timeout_drain");
    repeat (10) @(negedge clk);

    // Reset mid-wait aborts without TDC_stop
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("midwait_start_seen", sb.size(), 0);
    stops_before = n_stop;
    reset_n = 1'b1;
    @(negedge clk);
    check("midwait_rst_start", tdc_start, 0);
    check("midwait_rst_stop", tdc_stop, 0);
    @(negedge clk);
    check("midwait_rst_start2", tdc_start, 0);
    check("midwait_rst_stop2", tdc_stop, 0);
    reset_n = 1'b0;
    repeat (20) @(negedge clk);
    check("midwait_no_stop", n_stop, stops_before);

    // Input already high at reset release registers as a rise
    reset_n = 1'b1;
    start   = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    push_exp(1'b1);
    @(negedge clk);
    check("release_start0", tdc_start, 0);
    check("release_stop0", tdc_stop, 0);
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain("release_drain");
    repeat (10) @(negedge clk);

    // Soak: 100 random start/stop pairs
    for (int i = 0; i < 100; i++) begin
      gap = $urandom_range(485, 395);
      pulse(1'b0, 1'b0, 1'b1);
      #(gap - 40);
      gap = $urandom_range(485, 395);
      pulse(1'b1, 1'b0, 1'b1);
      #(gap - 40);
    end
    drain("soak_drain");
    repeat (20) @(negedge clk);

    check("total_starts", n_start, n_exp_start);
    check("total_stops", n_stop, n_exp_stop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
